// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter that shares one external-SRAM controller between NUM_REQ requesters.
// Each grant performs a single read or write, sequences the controller's level-enable
// handshake, bounds reads with a timeout and waits out controller recovery before re-arbitrating.
module sram_port_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned WR_HOLD    = 12,
    parameter int unsigned RD_TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // requester side
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic                      rsp_err_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    // controller side
    output logic                      mem_rd_en_o,
    output logic                      mem_wr_en_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_wdata_o,
    input  logic                      mem_rd_valid_i,
    input  logic [DATA_W-1:0]         mem_rdata_i,
    input  logic                      mem_busy_i
);

    localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntMax = (WR_HOLD > RD_TIMEOUT) ? WR_HOLD : RD_TIMEOUT;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] RdLast = CntW'(RD_TIMEOUT - 1);
    localparam logic [CntW-1:0] WrLast = CntW'(WR_HOLD - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StRd,
        StWr,
        StDone,
        StRecover
    } state_e;

    state_e              state_q;
    logic [IdxW-1:0]     last_q;
    logic [IdxW-1:0]     win_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [CntW-1:0]     cnt_q;

    logic [NUM_REQ-1:0]  req_ready_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                mem_rd_en_q;
    logic                mem_wr_en_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic [ADDR_W-1:0]   addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]   wdata_arr [NUM_REQ];
    logic [IdxW-1:0]     pick_idx;
    logic [IdxW-1:0]     cand;
    logic                pick_found;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IdxW-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Split the packed request buses into per-requester fields.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr_i[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = req_wdata_i[g*DATA_W +: DATA_W];
    end

    // Round-robin pick: first active requester scanning upward from last_q+1, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdxW'((32'(last_q) + k) % NUM_REQ);
            if (!pick_found && req_valid_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Transaction sequencer; every output comes straight from a register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            last_q      <= IdxW'(NUM_REQ - 1);
            win_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Fields are held until req_ready, so latching them here is safe.
                    if (pick_found) begin
                        win_q       <= pick_idx;
                        we_q        <= req_we_i[pick_idx];
                        addr_q      <= addr_arr[pick_idx];
                        wdata_q     <= wdata_arr[pick_idx];
                        req_ready_q <= onehot(pick_idx);
                        state_q     <= StGrant;
                    end
                end
                StGrant: begin
                    req_ready_q <= '0;
                    last_q      <= win_q;
                    cnt_q       <= '0;
                    mem_addr_q  <= addr_q;
                    if (we_q) begin
                        mem_wr_en_q <= 1'b1;
                        mem_wdata_q <= wdata_q;
                        state_q     <= StWr;
                    end else begin
                        mem_rd_en_q <= 1'b1;
                        state_q     <= StRd;
                    end
                end
                StRd: begin
                    // A valid arriving on the final timeout cycle still counts as data.
                    if (mem_rd_valid_i) begin
                        rsp_rdata_q <= mem_rdata_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= onehot(win_q);
                        mem_rd_en_q <= 1'b0;
                        state_q     <= StDone;
                    end else if (cnt_q == RdLast) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= onehot(win_q);
                        mem_rd_en_q <= 1'b0;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWr: begin
                    if (cnt_q == WrLast) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= onehot(win_q);
                        mem_wr_en_q <= 1'b0;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    rsp_valid_q <= '0;
                    state_q     <= StRecover;
                end
                StRecover: begin
                    if (!mem_busy_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_rd_en_o = mem_rd_en_q;
    assign mem_wr_en_o = mem_wr_en_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
